// File: rtl/edge_scan_rd_pkg.sv
// rtl/edge_scan_rd_pkg.sv - shared constants and FSM encoding for the edge accumulator scanner
//
// Purpose : geometry of the scanned accumulator (128 words of 32 bits), counter
//           widths and the scanner state encoding, shared by all edge_scan_rd files.
// Ports   : none (package).
package edge_scan_rd_pkg;

  localparam int WORDS  = 128;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 7;
  localparam int CNT_W  = 13;
  localparam int POP_W  = 6;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/edge_scan_rd_popcnt32.sv
// rtl/edge_scan_rd_popcnt32.sv - 32-bit combinational population count
//
// Purpose : number of set bits in one accumulator word.
// Ports   : word_i  [31:0] in  - word to count
//           count_o [5:0]  out - number of ones in word_i (0..32)
module popcnt32
  import edge_scan_rd_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [POP_W-1:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WORD_W; i++) begin
      count_o = count_o + POP_W'(word_i[i]);
    end
  end

endmodule

// File: rtl/edge_scan_rd.sv
// rtl/edge_scan_rd.sv - scans the 128-word edge accumulator and streams its words out
//
// Purpose : on start, walks idx 0..127 over the accumulator, captures each word,
//           totals its set bits, and offers (optionally only non-zero) words on a
//           valid/ready stream tagged with their word index.
// Ports   : CLK, RST_n       in  - clock, asynchronous active-low reset
//           start            in  - one-cycle scan request (ignored while busy)
//           sel1 [2:0]       out - word-group select, idx[6:4]
//           sel2 [7:0]       out - word select, {4'b0, idx[3:0]}
//           result_imp [31:0] in - accumulator word addressed by sel1/sel2
//           m_valid/m_ready  out/in - stream handshake
//           m_data [31:0]    out - captured word
//           m_index [6:0]    out - index of m_data
//           busy, done       out - scan in progress / one-cycle end-of-scan pulse
//           bit_count [12:0] out - set bits over all words of the last scan
module edge_scan_rd
  import edge_scan_rd_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start,
  output logic [2:0]        sel1,
  output logic [7:0]        sel2,
  input  logic [WORD_W-1:0] result_imp,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_index,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   m_data_q, m_data_d;
  logic [IDX_W-1:0]    m_index_q, m_index_d;
  logic [CNT_W-1:0]    bit_count_q, bit_count_d;
  logic                m_valid_q, busy_q, done_q;
  logic [POP_W-1:0]    word_ones;

  popcnt32 u_popcnt (
    .word_i  (result_imp),
    .count_o (word_ones)
  );

  // The accumulator is addressed straight from the counter so the word is
  // available combinationally in the same SCAN cycle.
  assign sel1 = idx_q[6:4];
  assign sel2 = {4'b0000, idx_q[3:0]};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    m_data_d    = m_data_q;
    m_index_d   = m_index_q;
    bit_count_d = bit_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d       = '0;
          bit_count_d = '0;
          state_d     = ST_SCAN;
        end
      end

      ST_SCAN: begin
        m_data_d    = result_imp;
        m_index_d   = idx_q;
        bit_count_d = bit_count_q + CNT_W'(word_ones);
        if (SKIP_ZERO && (result_imp == '0)) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          state_d = ST_OUT;
        end
      end

      ST_OUT: begin
        if (m_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      m_data_q    <= '0;
      m_index_q   <= '0;
      bit_count_q <= '0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      m_data_q    <= m_data_d;
      m_index_q   <= m_index_d;
      bit_count_q <= bit_count_d;
      // Status flags are registered copies of the next state so they line up
      // exactly with the state they describe.
      m_valid_q   <= (state_d == ST_OUT);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_index   = m_index_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_edge_scan_rd.sv
// tb/tb_edge_scan_rd.sv - self-checking bench for edge_scan_rd
module tb_edge_scan_rd;

  logic CLK = 1'b0;
  logic RST_n;
  always #5 CLK = ~CLK;

  logic [31:0] mem [0:127];
  int          dsel;
  logic        start_r, ready_r;
  int          checks = 0;
  int          errors = 0;

  // Instance z skips zero words, instance a emits all words.
  logic        start_z, ready_z, valid_z, busy_z, done_z;
  logic [2:0]  sel1_z;
  logic [7:0]  sel2_z;
  logic [31:0] res_z, data_z;
  logic [6:0]  index_z;
  logic [12:0] bc_z;
  logic        start_a, ready_a, valid_a, busy_a, done_a;
  logic [2:0]  sel1_a;
  logic [7:0]  sel2_a;
  logic [31:0] res_a, data_a;
  logic [6:0]  index_a;
  logic [12:0] bc_a;

  assign start_z = start_r & (dsel == 0);
  assign start_a = start_r & (dsel == 1);
  assign ready_z = (dsel == 0) ? ready_r : 1'b1;
  assign ready_a = (dsel == 1) ? ready_r : 1'b1;
  assign res_z   = mem[{sel1_z, sel2_z[3:0]}];
  assign res_a   = mem[{sel1_a, sel2_a[3:0]}];

  edge_scan_rd #(.SKIP_ZERO(1'b1)) u_dut_z (
    .CLK(CLK), .RST_n(RST_n), .start(start_z), .sel1(sel1_z), .sel2(sel2_z),
    .result_imp(res_z), .m_valid(valid_z), .m_ready(ready_z), .m_data(data_z),
    .m_index(index_z), .busy(busy_z), .done(done_z), .bit_count(bc_z)
  );

  edge_scan_rd #(.SKIP_ZERO(1'b0)) u_dut_a (
    .CLK(CLK), .RST_n(RST_n), .start(start_a), .sel1(sel1_a), .sel2(sel2_a),
    .result_imp(res_a), .m_valid(valid_a), .m_ready(ready_a), .m_data(data_a),
    .m_index(index_a), .busy(busy_a), .done(done_a), .bit_count(bc_a)
  );

  logic        o_valid, o_busy, o_done;
  logic [2:0]  o_sel1;
  logic [7:0]  o_sel2;
  logic [31:0] o_data;
  logic [6:0]  o_index;
  logic [12:0] o_bc;
  assign o_valid = (dsel == 0) ? valid_z : valid_a;
  assign o_busy  = (dsel == 0) ? busy_z  : busy_a;
  assign o_done  = (dsel == 0) ? done_z  : done_a;
  assign o_sel1  = (dsel == 0) ? sel1_z  : sel1_a;
  assign o_sel2  = (dsel == 0) ? sel2_z  : sel2_a;
  assign o_data  = (dsel == 0) ? data_z  : data_a;
  assign o_index = (dsel == 0) ? index_z : index_a;
  assign o_bc    = (dsel == 0) ? bc_z    : bc_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " m_valid"}, o_valid, 0);
    chk({tag, " busy"}, o_busy, 0);
    chk({tag, " done"}, o_done, 0);
    chk({tag, " bit_count"}, o_bc, 0);
    chk({tag, " m_data"}, o_data, 0);
    chk({tag, " m_index"}, o_index, 0);
    chk({tag, " sel1"}, o_sel1, 0);
    chk({tag, " sel2"}, o_sel2, 0);
  endtask

  // Drives one scan on the selected instance and checks it against a model
  // built directly from mem: the ordered list of words that must appear and
  // the total of set bits over all 128 words.
  task automatic run_scan(input string name, input int which, input bit rnd_ready,
                          input bit bp5, input bit start40, input bit rst64);
    int          exp_idx[$];
    int          exp_bc, got_n, cyc, done_n, done_cyc, first_valid, bp_left;
    bit          bp_done, s40_done, aborted;
    logic [31:0] hold_d;
    logic [6:0]  hold_i;
    exp_bc = 0; got_n = 0; done_n = 0; done_cyc = -1; first_valid = -1;
    bp_left = 0; bp_done = 0; s40_done = 0; aborted = 0;
    hold_d = '0; hold_i = '0;
    dsel = which;
    for (int i = 0; i < 128; i++) begin
      exp_bc += $countones(mem[i]);
      if (which == 1 || mem[i] != 32'h0) exp_idx.push_back(i);
    end

    start_r = 1'b1;
    ready_r = 1'b1;
    @(negedge CLK);
    start_r = 1'b0;
    cyc = 1;
    while (cyc < 2000) begin
      if (o_valid) begin
        chk({name, " valid_implies_busy"}, o_busy, 1);
        if (first_valid < 0) first_valid = cyc;
      end
      if (o_done) begin
        done_n++;
        done_cyc = cyc;
        chk({name, " bit_count_at_done"}, o_bc, exp_bc);
        chk({name, " valid_low_at_done"}, o_valid, 0);
        break;
      end
      if (rst64 && o_valid && o_index == 7'd64) begin
        RST_n = 1'b0;
        #1;
        chk_idle_outputs({name, " async_reset"});
        aborted = 1;
        break;
      end

      if (bp_left > 0) begin
        chk({name, " bp_hold_valid"}, o_valid, 1);
        chk({name, " bp_hold_data"}, o_data, hold_d);
        chk({name, " bp_hold_index"}, o_index, hold_i);
        ready_r = 1'b0;
        bp_left--;
      end else if (bp5 && !bp_done && o_valid && o_index == 7'd5) begin
        hold_d  = o_data;
        hold_i  = o_index;
        bp_done = 1;
        bp_left = 9;
        ready_r = 1'b0;
      end else begin
        ready_r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end

      if (o_valid && ready_r) begin
        if (got_n < exp_idx.size()) begin
          chk($sformatf("%s word%0d index", name, got_n), o_index, exp_idx[got_n]);
          chk($sformatf("%s word%0d data", name, got_n), o_data, mem[exp_idx[got_n]]);
        end else begin
          chk({name, " extra_word_index"}, o_index, 32'hFFFF_FFFF);
        end
        got_n++;
      end

      start_r = (start40 && !s40_done && o_valid && o_index == 7'd40);
      if (start_r) s40_done = 1;

      @(negedge CLK);
      cyc++;
    end
    start_r = 1'b0;
    ready_r = 1'b1;

    if (aborted) begin
      @(negedge CLK);
      chk({name, " no_done_in_reset"}, o_done, 0);
      chk({name, " no_busy_in_reset"}, o_busy, 0);
      RST_n = 1'b1;
      @(negedge CLK);
      chk({name, " no_done_after_reset"}, o_done, 0);
    end else begin
      chk({name, " done_pulses"}, done_n, 1);
      chk({name, " word_count"}, got_n, exp_idx.size());
      if (exp_idx.size() > 0)
        chk({name, " first_valid_cycle"}, first_valid, exp_idx[0] + 2);
      if (!rnd_ready)
        chk({name, " done_cycle"}, done_cyc, 129 + exp_idx.size() + (bp5 ? 10 : 0));
      @(negedge CLK);
      chk({name, " done_one_cycle"}, o_done, 0);
      chk({name, " busy_after_done"}, o_busy, 0);
      chk({name, " bit_count_held"}, o_bc, exp_bc);
      chk({name, " valid_idle"}, o_valid, 0);
    end
  endtask

  initial begin
    RST_n   = 1'b0;
    start_r = 1'b0;
    ready_r = 1'b1;
    dsel    = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    repeat (2) @(negedge CLK);
    dsel = 0; #1; chk_idle_outputs("reset_z");
    dsel = 1; #1; chk_idle_outputs("reset_a");
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);

    run_scan("all_zero_skip", 0, 0, 0, 0, 0);

    mem[0] = 32'h0000_0001; mem[37] = 32'hFFFF_FFFF; mem[127] = 32'h8000_0000;
    run_scan("three_words", 0, 0, 0, 0, 0);

    for (int i = 0; i < 128; i++) mem[i] = 32'hA5A5_A5A5;
    run_scan("all_a5", 1, 0, 0, 0, 0);

    for (int i = 0; i < 128; i++) mem[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
    mem[5] = $urandom | 32'h1; mem[6] = $urandom | 32'h2;
    run_scan("backpressure", 0, 0, 1, 0, 0);

    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    run_scan("mid_start", 1, 0, 0, 1, 0);

    for (int i = 0; i < 128; i++) mem[i] = ($urandom_range(0, 1) == 0) ? $urandom : 32'h0;
    mem[0] = 32'h1234_5678; mem[64] = 32'h0F0F_0000;
    run_scan("reset_at_64", 0, 0, 0, 0, 1);
    run_scan("rescan_after_reset", 0, 0, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 128; i++) mem[i] = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
      run_scan($sformatf("random%0d", r), r % 2, 1, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
